conv_encoder_frm: RTL

Parametrised, frame-terminated rate-1/2 convolutional encoder. It is the next-generation replacement for the fixed conv_code stage between M_sequence_gen and QAM.
- Generalises constraint length and generator polynomials.
- Adds a valid/ready handshake on both sides.
- Appends K-1 zero tail bits after every FRAME_LEN data bits, so each frame ends in state zero.

---
 rtl/conv_encoder_frm_pkg.sv | 10 +
 rtl/conv_encoder_frm_if.sv | 14 +
 rtl/conv_encoder_frm_core.sv | 22 ++
 rtl/conv_encoder_frm.sv | 75 +++++++
 4 files changed

// File: rtl/conv_encoder_frm_pkg.sv
// conv_encoder_frm_pkg: shared state type, default K=3 generators and the parity helper (package conv_pkg)
package conv_pkg;
  typedef enum logic {DATA, TAIL} state_t;
  localparam int CONV_K_MAX = 9;
  localparam logic [2:0] CONV_G0_K3 = 3'b111;
  localparam logic [2:0] CONV_G1_K3 = 3'b101;
  function automatic logic conv_parity(input logic [CONV_K_MAX-1:0] window, input logic [CONV_K_MAX-1:0] poly);
    return ^(window & poly);
  endfunction
endpackage

// File: rtl/conv_encoder_frm_if.sv
// conv_encoder_frm_if: input bit stream and coded symbol stream with valid/ready on both sides
interface conv_encoder_frm_if;
  logic in_bit;
  logic in_valid;
  logic in_ready;
  logic [1:0] conv_out;
  logic [1:0] out_mask;
  logic out_valid;
  logic out_ready;
  logic out_tail;
  logic out_last;
  modport slave (input in_bit, in_valid, out_ready, output in_ready, conv_out, out_mask, out_valid, out_tail, out_last);
  modport master (output in_bit, in_valid, out_ready, input in_ready, conv_out, out_mask, out_valid, out_tail, out_last);
endinterface

// File: rtl/conv_encoder_frm_core.sv
// conv_core: window/parity unit plus the K-1 bit shift register, advanced when shift is high
module conv_core
  import conv_pkg::*;
#(
  parameter int K = 3,
  parameter logic [K-1:0] G0 = CONV_G0_K3,
  parameter logic [K-1:0] G1 = CONV_G1_K3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       shift,
  input  logic       din,
  output logic [1:0] sym
);
  logic [K-2:0] sr;
  logic [K-1:0] window;
  assign window = {din, sr};
  assign sym = {conv_parity(CONV_K_MAX'(window), CONV_K_MAX'(G0)), conv_parity(CONV_K_MAX'(window), CONV_K_MAX'(G1))};
  always_ff @(posedge clk or posedge reset)
    if (reset) sr <= '0;
    else if (shift) sr <= window[K-1:1];
endmodule

// File: rtl/conv_encoder_frm.sv
// conv_encoder_frm: framed rate-1/2 convolutional encoder, K-1 zero tail per frame.
// Define CONV_PUNCT_EN for rate-2/3 puncturing of data symbols.
module conv_encoder_frm
  import conv_pkg::*;
#(
  parameter int K = 3,
  parameter logic [K-1:0] G0 = CONV_G0_K3,
  parameter logic [K-1:0] G1 = CONV_G1_K3,
  parameter int FRAME_LEN = 128
) (
  input logic clk,
  input logic reset,
  conv_encoder_frm_if.slave bus
);
  localparam int DW = $clog2(FRAME_LEN + 1);
  localparam int TW = $clog2(K);
  if (K < 2 || K > CONV_K_MAX || FRAME_LEN < 1) begin : g_bad_params
    $error("conv_encoder_frm: illegal K or FRAME_LEN");
  end
  state_t state;
  logic [DW-1:0] dcnt;
  logic [TW-1:0] tcnt;
  logic slot_free, take, gen, last_data, last_tail;
  logic [1:0] sym, data_out, data_mask;
  assign slot_free = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = (state == DATA) && slot_free && !reset;
  assign take = bus.in_valid && bus.in_ready;
  assign gen = (state == TAIL) && slot_free;
  assign last_data = dcnt == DW'(FRAME_LEN - 1);
  assign last_tail = tcnt == TW'(K - 2);
  conv_core #(.K(K), .G0(G0), .G1(G1)) u_core (
    .clk(clk),
    .reset(reset),
    .shift(take || gen),
    .din((state == DATA) && bus.in_bit),
    .sym(sym)
  );
`ifdef CONV_PUNCT_EN
  // odd in-frame indices drop the G1 bit
  assign data_out = dcnt[0] ? {sym[1], 1'b0} : sym;
  assign data_mask = dcnt[0] ? 2'b10 : 2'b11;
`else
  assign data_out = sym;
  assign data_mask = 2'b11;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= DATA;
      dcnt <= '0;
      tcnt <= '0;
      bus.out_valid <= 1'b0;
      bus.conv_out <= 2'b00;
      bus.out_mask <= 2'b11;
      bus.out_tail <= 1'b0;
      bus.out_last <= 1'b0;
    end else begin
      if (slot_free) bus.out_valid <= take || gen;
      if (take) begin
        bus.conv_out <= data_out;
        bus.out_mask <= data_mask;
        bus.out_tail <= 1'b0;
        bus.out_last <= 1'b0;
        state <= last_data ? TAIL : DATA;
        dcnt <= last_data ? '0 : dcnt + 1'b1;
      end
      if (gen) begin
        bus.conv_out <= sym;
        bus.out_mask <= 2'b11;
        bus.out_tail <= 1'b1;
        bus.out_last <= last_tail;
        state <= last_tail ? DATA : TAIL;
        tcnt <= last_tail ? '0 : tcnt + 1'b1;
      end
    end
endmodule
